// File: rtl/luythua_n_pkg.sv
// Shared definitions for the FP32 power unit and its sequential multiplier.
// Kept in a package so the root/log/exp datapaths can reuse the same constants.
package luythua_n_pkg;

  localparam int FP_W  = 32;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;

  localparam logic [FP_W-1:0] FP_ONE  = 32'h3F80_0000;
  localparam logic [FP_W-1:0] FP_QNAN = 32'h7FC0_0000;
  localparam logic [FP_W-1:0] FP_INF  = 32'h7F80_0000;

  localparam logic [9:0] BIAS = 10'd127;

  // The exponent is accepted only up to 2^7 (so k fits in 8 bits).
  localparam logic [EXP_W-1:0] N_EXP_MAX    = 8'd134;
  localparam logic [EXP_W-1:0] N_SHIFT_BASE = 8'(127 + MAN_W);

  localparam int MUL_LAT   = 25;
  localparam int MUL_STEPS = MUL_LAT - 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONVERT,
    S_SQUARE,
    S_MULT,
    S_DONE
  } state_e;

  function automatic logic [2:0] msbPos(input logic [7:0] k);
    msbPos = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (k[i]) msbPos = 3'(i);
    end
  endfunction

endpackage

// File: rtl/nhan_seq.sv
// Sequential FP32 multiplier: 24 shift-add steps (first one on the go edge) plus a
// packing cycle in which valid, out and ovf are presented combinationally.
module nhan_seq
  import luythua_n_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            go,
  input  logic [FP_W-1:0] a,
  input  logic [FP_W-1:0] b,
  output logic [FP_W-1:0] out,
  output logic            valid,
  output logic            ovf
);

  logic        run_q, run_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        sign_q, sign_d;
  logic        zero_q, zero_d;
  logic [9:0]  expSum_q, expSum_d;
  logic [47:0] mcand_q, mcand_d;
  logic [23:0] mplier_q, mplier_d;
  logic [47:0] prod_q, prod_d;

  logic [9:0]       expAdj;
  logic [MAN_W-1:0] manOut;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_q    <= 1'b0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      zero_q   <= 1'b0;
      expSum_q <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
    end else begin
      run_q    <= run_d;
      cnt_q    <= cnt_d;
      sign_q   <= sign_d;
      zero_q   <= zero_d;
      expSum_q <= expSum_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
    end
  end

  assign valid = run_q && (cnt_q == 5'(MUL_STEPS));

  // The go edge already consumes multiplier bit 0, so only 23 further steps follow.
  always_comb begin
    run_d    = run_q;
    cnt_d    = cnt_q;
    sign_d   = sign_q;
    zero_d   = zero_q;
    expSum_d = expSum_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    if (!run_q) begin
      if (go) begin
        run_d    = 1'b1;
        cnt_d    = 5'd1;
        sign_d   = a[31] ^ b[31];
        zero_d   = (a[30:23] == '0) || (b[30:23] == '0);
        expSum_d = {2'b00, a[30:23]} + {2'b00, b[30:23]} - BIAS;
        mcand_d  = {23'd0, 1'b1, a[22:0], 1'b0};
        mplier_d = {1'b0, 1'b1, b[22:1]};
        prod_d   = b[0] ? {24'd0, 1'b1, a[22:0]} : '0;
      end
    end else if (valid) begin
      run_d = 1'b0;
      cnt_d = '0;
    end else begin
      if (mplier_q[0]) prod_d = prod_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 5'd1;
    end
  end

  assign expAdj = prod_q[47] ? (expSum_q + 10'd1) : expSum_q;
  assign manOut = prod_q[47] ? prod_q[46:24] : prod_q[45:23];

  always_comb begin
    out = {sign_q, 31'd0};
    ovf = 1'b0;
    if (valid && !zero_q) begin
      if ($signed(expAdj) >= $signed(10'd255)) begin
        out = {sign_q, FP_INF[30:0]};
        ovf = 1'b1;
      end else if ($signed(expAdj) > $signed(10'd0)) begin
        out = {sign_q, expAdj[7:0], manOut};
      end
    end
  end

endmodule

// File: rtl/luythua_n.sv
// FP32 integer power y^n: converts n to an 8-bit k, then left-to-right
// square-and-multiply over a single shared sequential multiplier.
module luythua_n
  import luythua_n_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [FP_W-1:0] y,
  input  logic [FP_W-1:0] n,
  output logic            busy,
  output logic            done,
  output logic [FP_W-1:0] ketqua,
  output logic            err,
  output logic            ovf
);

  state_e state_q, state_d;

  logic [FP_W-1:0] y_q, y_d;
  logic [FP_W-1:0] n_q, n_d;
  logic [FP_W-1:0] acc_q, acc_d;
  logic [7:0]      k_q, k_d;
  logic [2:0]      j_q, j_d;
  logic            mulRun_q, mulRun_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [FP_W-1:0] ketqua_q, ketqua_d;
  logic            err_q, err_d;
  logic            ovf_q, ovf_d;

  logic [EXP_W-1:0] nExp;
  logic [EXP_W-1:0] shAmt;
  logic             nInvalid;
  logic [7:0]       kConv;

  logic            mulGo;
  logic [FP_W-1:0] mulB;
  logic [FP_W-1:0] mulOut;
  logic            mulValid;
  logic            mulOvf;

  assign nExp     = n_q[30:23];
  assign nInvalid = n_q[31] || (nExp < FP_ONE[30:23]) || (nExp > N_EXP_MAX);
  assign shAmt    = N_SHIFT_BASE - nExp;
  // Fraction bits of n fall off the right: n=2.9 gives k=2.
  assign kConv    = 8'({1'b1, n_q[22:0]} >> shAmt);

  assign mulGo = ((state_q == S_SQUARE) || (state_q == S_MULT)) && !mulRun_q;
  assign mulB  = (state_q == S_MULT) ? y_q : acc_q;

  nhan_seq u_nhan (
    .clk   (clk),
    .rst_n (rst_n),
    .go    (mulGo),
    .a     (acc_q),
    .b     (mulB),
    .out   (mulOut),
    .valid (mulValid),
    .ovf   (mulOvf)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      y_q      <= '0;
      n_q      <= '0;
      acc_q    <= '0;
      k_q      <= '0;
      j_q      <= '0;
      mulRun_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ketqua_q <= '0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      y_q      <= y_d;
      n_q      <= n_d;
      acc_q    <= acc_d;
      k_q      <= k_d;
      j_q      <= j_d;
      mulRun_q <= mulRun_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ketqua_q <= ketqua_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
    end
  end

  // The CHECK decision is folded into the edge that completes each multiply.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (start) state_d = S_CONVERT;
      S_CONVERT: state_d = (nInvalid || (kConv == 8'd1)) ? S_DONE : S_SQUARE;
      S_SQUARE: begin
        if (mulValid) begin
          if (mulOvf)              state_d = S_DONE;
          else if (k_q[j_q])       state_d = S_MULT;
          else if (j_q == 3'd0)    state_d = S_DONE;
          else                     state_d = S_SQUARE;
        end
      end
      S_MULT: begin
        if (mulValid) state_d = (mulOvf || (j_q == 3'd0)) ? S_DONE : S_SQUARE;
      end
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    y_d      = y_q;
    n_d      = n_q;
    acc_d    = acc_q;
    k_d      = k_q;
    j_d      = j_q;
    mulRun_d = mulRun_q;
    busy_d   = busy_q;
    done_d   = done_q;
    ketqua_d = ketqua_q;
    err_d    = err_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          y_d    = y;
          n_d    = n;
          done_d = 1'b0;
          err_d  = 1'b0;
          ovf_d  = 1'b0;
          busy_d = 1'b1;
        end
      end
      S_CONVERT: begin
        if (nInvalid) begin
          acc_d = FP_QNAN;
          err_d = 1'b1;
        end else begin
          acc_d = y_q;
          k_d   = kConv;
          j_d   = (kConv == 8'd1) ? 3'd0 : (msbPos(kConv) - 3'd1);
        end
      end
      S_SQUARE, S_MULT: begin
        if (mulGo) mulRun_d = 1'b1;
        if (mulValid) begin
          mulRun_d = 1'b0;
          acc_d    = mulOut;
          if (mulOvf) begin
            ovf_d = 1'b1;
          end else if (j_q != 3'd0) begin
            if ((state_q == S_MULT) || !k_q[j_q]) j_d = j_q - 3'd1;
          end
        end
      end
      S_DONE: begin
        ketqua_d = acc_q;
        done_d   = 1'b1;
        busy_d   = 1'b0;
      end
      default: ;
    endcase
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign ketqua = ketqua_q;
  assign err    = err_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_luythua_n.sv
// Scoreboard bench for luythua_n: stimulus pushes hand-computed results,
// a monitor pops and compares whenever done rises.
module tb_luythua_n;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] y = '0;
  logic [31:0] n = '0;
  logic        busy, done, err, ovf;
  logic [31:0] ketqua;

  luythua_n dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .y      (y),
    .n      (n),
    .busy   (busy),
    .done   (done),
    .ketqua (ketqua),
    .err    (err),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  int cycleCnt = 0;
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  typedef struct {
    string       name;
    logic [31:0] ketqua;
    logic        err;
    logic        ovf;
    int          latency;
    int          acceptCycle;
  } exp_t;

  exp_t sbQ[$];
  exp_t monEntry;
  int   compared = 0;
  int   mismatched = 0;
  logic prevDone = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Monitor: every rising done is matched against the oldest expectation.
  always @(negedge clk) begin
    if (done && !prevDone) begin
      if (sbQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_done: got ketqua 0x%08h, expected no result", ketqua);
      end else begin
        monEntry = sbQ.pop_front();
        checkOutput({monEntry.name, "_ketqua"}, ketqua, monEntry.ketqua);
        checkOutput({monEntry.name, "_err"}, 32'(err), 32'(monEntry.err));
        checkOutput({monEntry.name, "_ovf"}, 32'(ovf), 32'(monEntry.ovf));
        checkOutput({monEntry.name, "_busy"}, 32'(busy), 32'd0);
        checkOutput({monEntry.name, "_latency"}, 32'(cycleCnt - monEntry.acceptCycle),
                    32'(monEntry.latency));
      end
    end
    prevDone = done;
  end

  task automatic applyStimulus(input string name, input logic [31:0] yv, input logic [31:0] nv,
                               input logic [31:0] expK, input logic expErr, input logic expOvf,
                               input int expLat, input bit doPush, output int acceptCycle);
    exp_t e;
    @(negedge clk);
    y = yv;
    n = nv;
    start = 1'b1;
    @(posedge clk);
    #1;
    acceptCycle = cycleCnt;
    if (doPush) begin
      e.name = name;
      e.ketqua = expK;
      e.err = expErr;
      e.ovf = expOvf;
      e.latency = expLat;
      e.acceptCycle = acceptCycle;
      sbQ.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitResult(input string name);
    int i;
    for (i = 0; i < 600; i++) begin
      if (sbQ.size() == 0) break;
      @(negedge clk);
    end
    if (sbQ.size() != 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL %s_timeout: got no done, expected done within 600 cycles", name);
      sbQ.delete();
    end
  endtask

  task automatic runVector(input string name, input logic [31:0] yv, input logic [31:0] nv,
                           input logic [31:0] expK, input logic expErr, input logic expOvf,
                           input int expLat);
    int acc;
    applyStimulus(name, yv, nv, expK, expErr, expOvf, expLat, 1'b1, acc);
    waitResult(name);
  endtask

  task automatic checkAllZero(input string prefix);
    checkOutput({prefix, "_busy"}, 32'(busy), 32'd0);
    checkOutput({prefix, "_done"}, 32'(done), 32'd0);
    checkOutput({prefix, "_ketqua"}, ketqua, 32'd0);
    checkOutput({prefix, "_err"}, 32'(err), 32'd0);
    checkOutput({prefix, "_ovf"}, 32'(ovf), 32'd0);
  endtask

  initial begin
    int acc;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkAllZero("reset");
    rst_n = 1'b1;

    runVector("pow2_3",     32'h4000_0000, 32'h4040_0000, 32'h4100_0000, 1'b0, 1'b0, 52);
    runVector("neg_sq",     32'hBFC0_0000, 32'h4000_0000, 32'h4010_0000, 1'b0, 1'b0, 27);
    runVector("neg_cube",   32'hBFC0_0000, 32'h4040_0000, 32'hC058_0000, 1'b0, 1'b0, 52);
    runVector("k_one",      32'h40A0_0000, 32'h3F80_0000, 32'h40A0_0000, 1'b0, 1'b0, 2);
    runVector("n_half",     32'h40A0_0000, 32'h3F00_0000, 32'h7FC0_0000, 1'b1, 1'b0, 2);
    runVector("n_neg",      32'h40A0_0000, 32'hC000_0000, 32'h7FC0_0000, 1'b1, 1'b0, 2);
    runVector("n_256",      32'h40A0_0000, 32'h4380_0000, 32'h7FC0_0000, 1'b1, 1'b0, 2);
    runVector("ovf_sq",     32'h7149_F2CA, 32'h4000_0000, 32'h7F80_0000, 1'b0, 1'b1, 27);
    runVector("ovf_abort",  32'h7149_F2CA, 32'h4040_0000, 32'h7F80_0000, 1'b0, 1'b1, 27);
    runVector("zero_5",     32'h0000_0000, 32'h40A0_0000, 32'h0000_0000, 1'b0, 1'b0, 77);
    runVector("three_5",    32'h4040_0000, 32'h40A0_0000, 32'h4373_0000, 1'b0, 1'b0, 77);
    runVector("n_trunc",    32'h4040_0000, 32'h4039_999A, 32'h4110_0000, 1'b0, 1'b0, 27);
    runVector("k_255",      32'h3F80_0000, 32'h437F_0000, 32'h3F80_0000, 1'b0, 1'b0, 352);
    runVector("underflow",  32'h1F80_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 1'b0, 27);

    // A start pulse (with new operands) while busy must not disturb the running job.
    applyStimulus("ignore", 32'h4000_0000, 32'h4040_0000, 32'h4100_0000, 1'b0, 1'b0, 52,
                  1'b1, acc);
    repeat (8) @(negedge clk);
    checkOutput("ignore_busy", 32'(busy), 32'd1);
    y = 32'h4040_0000;
    n = 32'h40A0_0000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitResult("ignore");

    // Reset in the middle of the second multiply of 2.0^3.
    applyStimulus("rst_mid", 32'h4000_0000, 32'h4040_0000, 32'h0, 1'b0, 1'b0, 0, 1'b0, acc);
    while (cycleCnt < acc + 29) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkAllZero("rst_mid");
    rst_n = 1'b1;

    runVector("after_rst",  32'h4000_0000, 32'h4040_0000, 32'h4100_0000, 1'b0, 1'b0, 52);

    repeat (60) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
